// File: rtl/median_window_filter.sv
// Per-channel median of an NxN RGB window using an odd-even transposition sort.
// The sort runs one compare-swap phase per clock, and the result is handed off on a valid/ack handshake.
module median_window_filter #(
   parameter int WINDOW_SIZE = 3,
   parameter int DATA_WIDTH  = 24,
   parameter int CH_WIDTH    = DATA_WIDTH / 3
) (
   input  logic                                             Med_Clk,
   input  logic                                             Med_Rset,
   input  logic [DATA_WIDTH*WINDOW_SIZE*WINDOW_SIZE-1:0]    Med_Wind_Data,
   input  logic                                             Med_Wind_RDY,
   output logic                                             Med_Busy,
   output logic [DATA_WIDTH-1:0]                            Med_Pixel,
   output logic                                             Med_Valid,
   input  logic                                             Med_Ack
);

   localparam int NPIX    = WINDOW_SIZE * WINDOW_SIZE;
   localparam int MID     = (NPIX - 1) / 2;
   localparam int PHASE_W = $clog2(NPIX);
   localparam int WIN_W   = DATA_WIDTH * NPIX;

   typedef logic [NPIX-1:0][CH_WIDTH-1:0] ch_arr_t;
   typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

   state_t               state;
   logic [PHASE_W-1:0]   phase;
   logic                 rdy_q;
   logic                 start;
   ch_arr_t              r_arr, g_arr, b_arr;
   ch_arr_t              r_in, g_in, b_in;
   ch_arr_t              r_nxt, g_nxt, b_nxt;

   // One transposition phase; even phases pair (0,1),(2,3)..., odd phases (1,2),(3,4)...
   function automatic ch_arr_t oet_phase(input ch_arr_t a, input logic odd);
      ch_arr_t res;
      res = a;
      for (int i = 0; i < NPIX - 1; i++) begin
         if ((odd == 1'(i % 2)) && (a[i] > a[i+1])) begin
            res[i]   = a[i+1];
            res[i+1] = a[i];
         end
      end
      return res;
   endfunction

   assign start = Med_Wind_RDY & ~rdy_q;

   // Pixel 0 lives at the MSBs of the flattened window.
   always_comb begin
      r_in = '0;
      g_in = '0;
      b_in = '0;
      for (int i = 0; i < NPIX; i++) begin
         r_in[i] = Med_Wind_Data[WIN_W-1-DATA_WIDTH*i -: CH_WIDTH];
         g_in[i] = Med_Wind_Data[WIN_W-1-DATA_WIDTH*i-CH_WIDTH -: CH_WIDTH];
         b_in[i] = Med_Wind_Data[WIN_W-1-DATA_WIDTH*i-2*CH_WIDTH -: CH_WIDTH];
      end
   end

   always_comb begin
      r_nxt = oet_phase(r_arr, phase[0]);
      g_nxt = oet_phase(g_arr, phase[0]);
      b_nxt = oet_phase(b_arr, phase[0]);
   end

   always_ff @(posedge Med_Clk) begin
      if (Med_Rset) begin
         state     <= IDLE;
         phase     <= '0;
         rdy_q     <= 1'b1;
         r_arr     <= '0;
         g_arr     <= '0;
         b_arr     <= '0;
         Med_Busy  <= 1'b0;
         Med_Valid <= 1'b0;
         Med_Pixel <= '0;
      end else begin
         // Tracks the level even while busy, so a held level never re-triggers.
         rdy_q <= Med_Wind_RDY;
         unique case (state)
            IDLE: begin
               if (start) begin
                  r_arr    <= r_in;
                  g_arr    <= g_in;
                  b_arr    <= b_in;
                  phase    <= '0;
                  Med_Busy <= 1'b1;
                  state    <= SORT;
               end
            end
            SORT: begin
               r_arr <= r_nxt;
               g_arr <= g_nxt;
               b_arr <= b_nxt;
               phase <= phase + PHASE_W'(1);
               if (phase == PHASE_W'(NPIX - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (!Med_Valid) begin
                  Med_Pixel <= DATA_WIDTH'({r_arr[MID], g_arr[MID], b_arr[MID]});
                  Med_Valid <= 1'b1;
               end else if (Med_Ack) begin
                  Med_Valid <= 1'b0;
                  Med_Busy  <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               Med_Busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/median_window_filter.md
Name: median_window_filter

Overview:
- Consumes one flattened NxN window of RGB pixels from the upstream window reader.
- Computes the per-channel median with an iterative odd-even transposition sort, one compare-swap phase per clock.
- Presents the filtered pixel to the downstream write-back stage on a valid/acknowledge handshake.
- Sits directly downstream of the window reader and upstream of the output-image memory writer.

Parameters:
- WINDOW_SIZE, 3, window edge length N; must be odd.
- DATA_WIDTH, 24, pixel width; R in [23:16], G in [15:8], B in [7:0].
- CH_WIDTH, DATA_WIDTH/3, per-channel width (8).
- Derived, not overridable: NPIX = WINDOW_SIZE*WINDOW_SIZE (9); MID = (NPIX-1)/2 (4).

Ports:
- Med_Clk  in  1  sole clock; all logic on rising edge.
- Med_Rset  in  1  synchronous, active-high reset.
- Med_Wind_Data  in  DATA_WIDTH*NPIX  window from the reader. Pixel i occupies bits [DATA_WIDTH*NPIX-1-DATA_WIDTH*i -: DATA_WIDTH], so pixel 0 is at the MSBs. Order is row-major.
- Med_Wind_RDY  in  1  window-ready level from the reader; held high until the reader is disabled.
- Med_Busy  out  1  high whenever the FSM is not in IDLE.
- Med_Pixel  out  DATA_WIDTH  median pixel {R_med, G_med, B_med}.
- Med_Valid  out  1  Med_Pixel is valid.
- Med_Ack  in  1  downstream has consumed Med_Pixel.

Behaviour:
- Reset (sampled on Med_Clk while Med_Rset=1), from any state including mid-sort:
  - State goes to IDLE; Med_Busy=0, Med_Valid=0, Med_Pixel=0.
  - Phase counter=0; sort registers cleared.
  - Edge-detect register rdy_q is set to 1, so a Med_Wind_RDY level held through reset does not start a sort.
- Start condition: start = Med_Wind_RDY & ~rdy_q. rdy_q <= Med_Wind_RDY every cycle.
- States:
  - IDLE: on start, unpack all NPIX pixels into three arrays of NPIX x CH_WIDTH registers, set phase=0, go to SORT. Otherwise stay in IDLE.
  - SORT: one phase per cycle, applied to all three channels in parallel.
    - Even phase (phase[0]=0): compare-swap pairs (0,1),(2,3),...
    - Odd phase: compare-swap pairs (1,2),(3,4),...
    - Each swap leaves the smaller value at the lower index. Unpaired end elements are unchanged.
    - After phase NPIX-1, go to DONE.
  - DONE: Med_Pixel = {R[MID],G[MID],B[MID]} and Med_Valid=1, both registered on entry.
    - Med_Pixel stays stable while Med_Valid=1.
    - When Med_Ack=1 is sampled, the next cycle has Med_Valid=0 and state IDLE. Med_Pixel holds its last value.
- Latency: start sampled at edge k; SORT phases occupy edges k+1..k+NPIX; Med_Valid first high after edge k+NPIX+1 (k+10 for N=3). Minimum window-to-window period is 12 cycles with immediate Ack.
- Comparisons are unsigned on CH_WIDTH bits. There is no carry or overflow path; the output is always one of the input channel values.
- Channels are sorted independently, so the output pixel need not be any single input pixel.
- Boundary cases:
  - A Med_Wind_RDY rising edge while Med_Busy=1 is dropped, not queued. rdy_q still tracks the level, so a level that stays high is not re-detected later.
  - Med_Ack while Med_Valid=0 is ignored.
  - Ack and a new rising edge in the same DONE cycle: Ack completes, the edge is dropped.
  - Med_Wind_Data is sampled only on the start cycle; later changes have no effect.
  - Med_Wind_RDY falling mid-sort has no effect.

Test Plan:
- Reset with Med_Wind_RDY held high, then release -> Med_Busy and Med_Valid stay 0 for 20 cycles; no sort is started.
- All nine pixels 0x102030, RDY 0->1 at edge k -> Med_Busy=1 from k+1; Med_Valid=1 after edge k+10; Med_Pixel=0x102030.
- Pixels i=0..8 with R=9-i, G=i, B={200,3,50,50,7,255,0,1,100} -> Med_Pixel=0x050432.
- Hold Med_Ack=0 for 15 cycles after Valid -> Valid and Pixel stable throughout. Pulse Ack for 1 cycle -> Valid=0 and Busy=0 the next cycle.
- Second RDY rising edge at sort phase 3 -> ignored. Exactly one Valid with the first window's result; no second Valid without a fresh 0->1 edge.
- Assert Med_Rset at sort phase 5 -> next cycle IDLE, Valid=0, Pixel=0. A new window then gives the correct median with 10-cycle latency.
